// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// cache_mem_arbiter: shares one memory read/write port between icache and dcache.
// One outstanding read (round-robin or dcache-priority), one-entry write-back buffer.
module cache_mem_arbiter #(
  parameter int RR_EN  = 1,
  parameter int LINE_W = 128
) (
  input  logic              clk_g,
  input  logic              resetn,
  input  logic              ic_rd_req,
  input  logic [2:0]        ic_rd_type,
  input  logic [31:0]       ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [31:0]       ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [2:0]        dc_rd_type,
  input  logic [31:0]       dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [31:0]       dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [2:0]        dc_wr_type,
  input  logic [31:0]       dc_wr_addr,
  input  logic [3:0]        dc_wr_wstrb,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_wr_rdy,
  output logic              mem_rd_req,
  output logic [2:0]        mem_rd_type,
  output logic [31:0]       mem_rd_addr,
  input  logic              mem_rd_rdy,
  input  logic              mem_ret_valid,
  input  logic              mem_ret_last,
  input  logic [31:0]       mem_ret_data,
  output logic              mem_wr_req,
  output logic [2:0]        mem_wr_type,
  output logic [31:0]       mem_wr_addr,
  output logic [3:0]        mem_wr_wstrb,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic              mem_wr_rdy
);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rd_state_t;
  typedef enum logic {W_EMPTY, W_FULL} wr_state_t;
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  rd_state_t         rd_state, rd_state_nx;
  wr_state_t         wr_state, wr_state_nx;
  logic              rd_owner, last_grant;
  logic [2:0]        rd_type_q;
  logic [31:0]       rd_addr_q;
  logic [2:0]        wr_type_q;
  logic [31:0]       wr_addr_q;
  logic [3:0]        wr_wstrb_q;
  logic [LINE_W-1:0] wr_data_q;

  logic wr_accept, dc_hazard, ic_elig, dc_elig, grant_ic, grant_dc, ret_fwd;

  always_comb begin
    wr_accept = resetn && (wr_state == W_EMPTY) && dc_wr_req;
    // A read must not overtake a dirty line still waiting to reach memory.
    dc_hazard = ((wr_state == W_FULL) && (dc_rd_addr[31:4] == wr_addr_q[31:4])) ||
                (wr_accept && (dc_rd_addr[31:4] == dc_wr_addr[31:4]));
    ic_elig  = ic_rd_req;
    dc_elig  = dc_rd_req && !dc_hazard;
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (resetn && (rd_state == R_IDLE)) begin
      if (ic_elig && dc_elig) begin
        if ((RR_EN != 0) && (last_grant == OWN_DC)) grant_ic = 1'b1;
        else                                        grant_dc = 1'b1;
      end else begin
        grant_ic = ic_elig;
        grant_dc = dc_elig;
      end
    end
  end

  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      R_IDLE:  if (grant_ic || grant_dc)            rd_state_nx = R_REQ;
      R_REQ:   if (mem_rd_rdy)                      rd_state_nx = R_RESP;
      R_RESP:  if (mem_ret_valid && mem_ret_last)   rd_state_nx = R_IDLE;
      default:                                      rd_state_nx = R_IDLE;
    endcase
    wr_state_nx = wr_state;
    if (wr_state == W_FULL) begin
      if (mem_wr_rdy) wr_state_nx = W_EMPTY;
    end else if (wr_accept) begin
      wr_state_nx = W_FULL;
    end
  end

  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      rd_state   <= R_IDLE;
      wr_state   <= W_EMPTY;
      last_grant <= OWN_DC;
      rd_owner   <= OWN_IC;
    end else begin
      rd_state <= rd_state_nx;
      wr_state <= wr_state_nx;
      if (grant_ic || grant_dc) begin
        rd_owner   <= grant_dc;
        last_grant <= grant_dc;
      end
    end
  end

  // Payload registers are qualified by the state registers, so they need no reset.
  always_ff @(posedge clk_g) begin
    if (grant_dc) begin
      rd_type_q <= dc_rd_type;
      rd_addr_q <= dc_rd_addr;
    end else if (grant_ic) begin
      rd_type_q <= ic_rd_type;
      rd_addr_q <= ic_rd_addr;
    end
    if (wr_accept) begin
      wr_type_q  <= dc_wr_type;
      wr_addr_q  <= dc_wr_addr;
      wr_wstrb_q <= dc_wr_wstrb;
      wr_data_q  <= dc_wr_data;
    end
  end

  assign ret_fwd      = resetn && (rd_state == R_RESP) && mem_ret_valid;
  assign ic_rd_rdy    = grant_ic;
  assign dc_rd_rdy    = grant_dc;
  assign ic_ret_valid = ret_fwd && (rd_owner == OWN_IC);
  assign dc_ret_valid = ret_fwd && (rd_owner == OWN_DC);
  assign ic_ret_last  = ic_ret_valid && mem_ret_last;
  assign dc_ret_last  = dc_ret_valid && mem_ret_last;
  assign ic_ret_data  = mem_ret_data;
  assign dc_ret_data  = mem_ret_data;

  assign mem_rd_req   = resetn && (rd_state == R_REQ);
  assign mem_rd_type  = rd_type_q;
  assign mem_rd_addr  = rd_addr_q;

  assign dc_wr_rdy    = resetn && (wr_state == W_EMPTY);
  assign mem_wr_req   = resetn && (wr_state == W_FULL);
  assign mem_wr_type  = wr_type_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_wstrb = wr_wstrb_q;
  assign mem_wr_data  = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// tb_cache_mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_cache_mem_arbiter;
  logic clk_g = 1'b0;
  always #5 clk_g = ~clk_g;

  logic         resetn;
  logic         ic_rd_req, dc_rd_req, dc_wr_req;
  logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
  logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_wr_rdy;
  logic [31:0]  mem_ret_data;

  logic         ic_rd_rdy, ic_ret_valid, ic_ret_last, dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_wr_rdy;
  logic [31:0]  ic_ret_data, dc_ret_data, mem_rd_addr, mem_wr_addr;
  logic         mem_rd_req, mem_wr_req;
  logic [2:0]   mem_rd_type, mem_wr_type;
  logic [3:0]   mem_wr_wstrb;
  logic [127:0] mem_wr_data;

  logic         ic_rd_rdy_f, ic_ret_valid_f, ic_ret_last_f, dc_rd_rdy_f, dc_ret_valid_f, dc_ret_last_f, dc_wr_rdy_f;
  logic [31:0]  ic_ret_data_f, dc_ret_data_f, mem_rd_addr_f, mem_wr_addr_f;
  logic         mem_rd_req_f, mem_wr_req_f;
  logic [2:0]   mem_rd_type_f, mem_wr_type_f;
  logic [3:0]   mem_wr_wstrb_f;
  logic [127:0] mem_wr_data_f;

  cache_mem_arbiter #(.RR_EN(1), .LINE_W(128)) dut (
    .clk_g(clk_g), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr), .dc_wr_wstrb(dc_wr_wstrb),
    .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
    .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr), .mem_wr_wstrb(mem_wr_wstrb),
    .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy)
  );

  // Fixed-priority instance sharing the same stimulus; only its grants are examined.
  cache_mem_arbiter #(.RR_EN(0), .LINE_W(128)) dut_fp (
    .clk_g(clk_g), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy_f),
    .ic_ret_valid(ic_ret_valid_f), .ic_ret_last(ic_ret_last_f), .ic_ret_data(ic_ret_data_f),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy_f),
    .dc_ret_valid(dc_ret_valid_f), .dc_ret_last(dc_ret_last_f), .dc_ret_data(dc_ret_data_f),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr), .dc_wr_wstrb(dc_wr_wstrb),
    .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy_f),
    .mem_rd_req(mem_rd_req_f), .mem_rd_type(mem_rd_type_f), .mem_rd_addr(mem_rd_addr_f), .mem_rd_rdy(mem_rd_rdy),
    .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req_f), .mem_wr_type(mem_wr_type_f), .mem_wr_addr(mem_wr_addr_f), .mem_wr_wstrb(mem_wr_wstrb_f),
    .mem_wr_data(mem_wr_data_f), .mem_wr_rdy(mem_wr_rdy)
  );

  int checks = 0;
  int errors = 0;

  // Model: the outstanding read as a transaction record plus the buffered write.
  bit           m_busy, m_acc, m_own_dc, m_last_dc, m_wfull;
  int           m_beats;
  logic [2:0]   m_type, m_wtype;
  logic [31:0]  m_addr, m_waddr;
  logic [3:0]   m_wstrb;
  logic [127:0] m_wdata;
  bit           g_ic, g_dc, g_wr;
  int           rst_hold;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    bit wr_acc, blocked, want_ic, want_dc, fwd, rd_issue;
    g_ic = 0; g_dc = 0; g_wr = 0;
    if (!resetn) begin
      check("reset_outputs", {ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid, dc_wr_rdy, mem_rd_req, mem_wr_req}, '0);
      m_busy = 0; m_acc = 0; m_last_dc = 1; m_wfull = 0; m_beats = 0;
      return;
    end
    wr_acc  = dc_wr_req && !m_wfull;
    blocked = (m_wfull && dc_rd_addr[31:4] == m_waddr[31:4]) ||
              (wr_acc && dc_rd_addr[31:4] == dc_wr_addr[31:4]);
    want_ic = !m_busy && ic_rd_req;
    want_dc = !m_busy && dc_rd_req && !blocked;
    g_ic    = want_ic && (!want_dc || m_last_dc);
    g_dc    = want_dc && !g_ic;
    g_wr    = wr_acc;
    rd_issue = m_busy && !m_acc;
    fwd      = m_busy && m_acc && mem_ret_valid;

    check("ic_rd_rdy", ic_rd_rdy, g_ic);
    check("dc_rd_rdy", dc_rd_rdy, g_dc);
    check("mem_rd_req", mem_rd_req, rd_issue);
    if (rd_issue) begin
      check("mem_rd_addr", mem_rd_addr, m_addr);
      check("mem_rd_type", mem_rd_type, m_type);
    end
    check("ic_ret_valid", ic_ret_valid, fwd && !m_own_dc);
    check("dc_ret_valid", dc_ret_valid, fwd && m_own_dc);
    if (fwd && m_own_dc) begin
      check("dc_ret_last", dc_ret_last, mem_ret_last);
      check("dc_ret_data", dc_ret_data, mem_ret_data);
    end
    if (fwd && !m_own_dc) begin
      check("ic_ret_last", ic_ret_last, mem_ret_last);
      check("ic_ret_data", ic_ret_data, mem_ret_data);
    end
    check("dc_wr_rdy", dc_wr_rdy, !m_wfull);
    check("mem_wr_req", mem_wr_req, m_wfull);
    if (m_wfull) begin
      check("mem_wr_addr", mem_wr_addr, m_waddr);
      check("mem_wr_type", mem_wr_type, m_wtype);
      check("mem_wr_wstrb", mem_wr_wstrb, m_wstrb);
      check("mem_wr_data", mem_wr_data, m_wdata);
    end

    if (fwd) begin
      m_beats++;
      if (mem_ret_last) m_busy = 0;
    end else if (rd_issue && mem_rd_rdy) begin
      m_acc = 1;
    end
    if (g_ic || g_dc) begin
      m_busy = 1; m_acc = 0; m_beats = 0; m_own_dc = g_dc; m_last_dc = g_dc;
      m_type = g_dc ? dc_rd_type : ic_rd_type;
      m_addr = g_dc ? dc_rd_addr : ic_rd_addr;
    end
    if (m_wfull && mem_wr_rdy) begin
      m_wfull = 0;
    end else if (wr_acc) begin
      m_wfull = 1; m_wtype = dc_wr_type; m_waddr = dc_wr_addr; m_wstrb = dc_wr_wstrb; m_wdata = dc_wr_data;
    end
  endtask

  task automatic adv();
    step();
    @(negedge clk_g);
  endtask

  function automatic logic [2:0] rand_type();
    case ($urandom_range(0, 3))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Four lines around 0x1200 so read/write line collisions are frequent.
  function automatic logic [31:0] rand_addr();
    return 32'h0000_1200 + (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic drive_random();
    if (rst_hold > 0) begin
      rst_hold--; resetn = 0;
    end else if ($urandom_range(0, 299) == 0) begin
      rst_hold = 1; resetn = 0;
    end else begin
      resetn = 1;
    end
    if (!(ic_rd_req && !g_ic)) begin
      ic_rd_req = ($urandom_range(0, 2) == 0); ic_rd_type = rand_type(); ic_rd_addr = rand_addr();
    end
    if (!(dc_rd_req && !g_dc)) begin
      dc_rd_req = ($urandom_range(0, 2) == 0); dc_rd_type = rand_type(); dc_rd_addr = rand_addr();
    end
    if (!(dc_wr_req && !g_wr)) begin
      dc_wr_req = ($urandom_range(0, 3) == 0); dc_wr_type = rand_type(); dc_wr_addr = rand_addr();
      dc_wr_wstrb = 4'($urandom_range(0, 15)); dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_rd_rdy = 1'($urandom_range(0, 1));
    mem_wr_rdy = ($urandom_range(0, 3) == 0);
    if (m_busy && m_acc) begin
      mem_ret_valid = 1'($urandom_range(0, 1));
      mem_ret_last  = (m_type != 3'b100) || (m_beats == 3);
    end else begin
      mem_ret_valid = ($urandom_range(0, 7) == 0);
      mem_ret_last  = 1'($urandom_range(0, 1));
    end
    mem_ret_data = $urandom;
  endtask

  initial begin
    resetn = 0; rst_hold = 0;
    ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
    dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
    dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
    mem_rd_rdy = 0; mem_ret_valid = 0; mem_ret_last = 0; mem_ret_data = 0; mem_wr_rdy = 0;
    m_busy = 0; m_acc = 0; m_own_dc = 0; m_last_dc = 1; m_wfull = 0; m_beats = 0;
    m_type = 0; m_addr = 0; m_wtype = 0; m_waddr = 0; m_wstrb = 0; m_wdata = 0;
    g_ic = 0; g_dc = 0; g_wr = 0;
    @(negedge clk_g);

    // Reset holds every handshake low even with requests present.
    ic_rd_req = 1; dc_wr_req = 1;
    #1; check("rst_ic_rd_rdy", ic_rd_rdy, 1'b0); check("rst_dc_wr_rdy", dc_wr_rdy, 1'b0);
    adv();
    ic_rd_req = 0; dc_wr_req = 0;
    #1; adv();

    // Lone icache line read.
    resetn = 1; ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0100;
    #1; check("A_ic_rd_rdy", ic_rd_rdy, 1'b1); adv();
    ic_rd_req = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rd_rdy = (i == 2);
      #1;
      check("A_mem_rd_req", mem_rd_req, 1'b1);
      check("A_mem_rd_addr", mem_rd_addr, 32'h1C00_0100);
      check("A_mem_rd_type", mem_rd_type, 3'b100);
      adv();
    end
    mem_rd_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ret_valid = 1; mem_ret_last = (i == 3); mem_ret_data = 32'hD0D0_0000 + 32'(i);
      #1;
      check("A_ic_ret_valid", ic_ret_valid, 1'b1);
      check("A_ic_ret_last", ic_ret_last, i == 3);
      check("A_ic_ret_data", ic_ret_data, 32'hD0D0_0000 + 32'(i));
      check("A_dc_ret_valid", dc_ret_valid, 1'b0);
      adv();
    end
    mem_ret_valid = 1; mem_ret_last = 1;
    #1; check("stray_ret", {ic_ret_valid, dc_ret_valid}, 2'b00); adv();

    // Simultaneous requesters straight out of reset.
    resetn = 0; #1; adv();
    resetn = 1;
    ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0100;
    dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_0200;
    mem_rd_rdy = 1; mem_ret_valid = 1; mem_ret_last = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i % 3 == 0) begin
        check("B_rr_grant", {ic_rd_rdy, dc_rd_rdy}, (i % 6 == 0) ? 2'b10 : 2'b01);
        check("B_fixed_grant", {ic_rd_rdy_f, dc_rd_rdy_f}, 2'b01);
      end
      adv();
    end
    ic_rd_req = 0; dc_rd_req = 0;

    // Write-back hazard against a buffered line.
    for (int c = 0; c < 8; c++) begin
      dc_wr_req = (c == 0); dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_1230;
      dc_wr_wstrb = 4'hF; dc_wr_data = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
      dc_rd_req = (c == 0) || (c >= 3); dc_rd_type = 3'b010;
      dc_rd_addr = (c == 0) ? 32'h0000_5670 : 32'h0000_1234;
      ic_rd_req = (c == 4); ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0300;
      mem_wr_rdy = (c == 6);
      #1;
      check("C_dc_rd_rdy", dc_rd_rdy, (c == 0) || (c == 7));
      check("C_ic_rd_rdy", ic_rd_rdy, c == 4);
      check("C_mem_wr_req", mem_wr_req, (c >= 1) && (c <= 6));
      if (c == 1) check("C_mem_wr_addr", mem_wr_addr, 32'h0000_1230);
      adv();
    end
    dc_rd_req = 0; ic_rd_req = 0; dc_wr_req = 0; mem_wr_rdy = 0;
    repeat (3) begin #1; adv(); end

    // Second write while the buffer is full; reads keep flowing.
    for (int c = 0; c < 7; c++) begin
      dc_wr_req = 1; dc_wr_type = 3'b010;
      dc_wr_addr  = (c == 0) ? 32'h0000_0040 : 32'h0000_0080;
      dc_wr_wstrb = (c == 0) ? 4'h3 : 4'hC;
      dc_wr_data  = (c == 0) ? 128'h1111 : 128'h2222;
      mem_wr_rdy = (c == 4);
      ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0500;
      #1;
      check("D_dc_wr_rdy", dc_wr_rdy, (c == 0) || (c == 5));
      check("D_ic_rd_rdy", ic_rd_rdy, c % 3 == 0);
      if (c == 6) begin
        check("D_mem_wr_addr", mem_wr_addr, 32'h0000_0080);
        check("D_mem_wr_data", mem_wr_data, 128'h2222);
      end
      adv();
    end
    ic_rd_req = 0; dc_wr_req = 0; mem_wr_rdy = 0;
    repeat (3) begin #1; adv(); end

    // Reset in the middle of a line response.
    mem_ret_valid = 0; mem_rd_rdy = 1;
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0200;
    #1; check("E_ic_rd_rdy", ic_rd_rdy, 1'b1); adv();
    ic_rd_req = 0; #1; adv();
    for (int i = 0; i < 2; i++) begin
      mem_ret_valid = 1; mem_ret_last = 0; mem_ret_data = 32'hBEEF_0000 + 32'(i);
      #1; check("E_beat_valid", ic_ret_valid, 1'b1); adv();
    end
    resetn = 0; ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0600;
    repeat (2) begin
      #1; check("E_rst_outputs", {ic_rd_rdy, ic_ret_valid, dc_ret_valid, dc_wr_rdy, mem_rd_req, mem_wr_req}, 6'b0);
      adv();
    end
    resetn = 1;
    #1; check("E_post_grant", ic_rd_rdy, 1'b1); check("E_leftover", ic_ret_valid, 1'b0); adv();
    ic_rd_req = 0; mem_ret_last = 1; mem_rd_rdy = 0;
    #1; check("E_leftover_last", ic_ret_valid, 1'b0); check("E_mem_rd_addr", mem_rd_addr, 32'h0000_0600); adv();
    mem_ret_valid = 0; ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;

    for (int n = 0; n < 4000; n++) begin
      drive_random();
      #1;
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
